// File: rtl/accu_arbiter.sv
// accu_arbiter: round-robin arbiter sharing one accumulator write port
// between NUM_CORES PLC cores, with per-core lock for multi-write bursts.
// Ports: CLK, CPU_Reset_N (async, active low); per-core CORE_Req,
// CORE_Lock, CORE_OPCode[2i+1:2i], CORE_ArgToSet[8i+7:8i] in;
// CORE_Grant, CORE_Ack, ACCU_WE/OPCode/ArgToSet/Owner, ARB_Busy,
// LOCK_Timeout out. All outputs registered.
// Build option: define ACCU_ARB_LOCK_TIMEOUT_EN to force-release a lock
// after LOCK_TIMEOUT idle cycles; otherwise LOCK_Timeout is tied to 0.
module accu_arbiter #(
  parameter int NUM_CORES    = 4,
  parameter int OWNER_W      = 2,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic                   CLK,
  input  logic                   CPU_Reset_N,
  input  logic [NUM_CORES-1:0]   CORE_Req,
  input  logic [NUM_CORES-1:0]   CORE_Lock,
  input  logic [2*NUM_CORES-1:0] CORE_OPCode,
  input  logic [8*NUM_CORES-1:0] CORE_ArgToSet,
  output logic [NUM_CORES-1:0]   CORE_Grant,
  output logic [NUM_CORES-1:0]   CORE_Ack,
  output logic                   ACCU_WE,
  output logic [1:0]             ACCU_OPCode,
  output logic [7:0]             ACCU_ArgToSet,
  output logic [OWNER_W-1:0]     ACCU_Owner,
  output logic                   ARB_Busy,
  output logic                   LOCK_Timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_LOCKED
  } state_e;

  state_e state_q, state_d;
  logic [OWNER_W-1:0]   ptr_q, ptr_d;
  logic [OWNER_W-1:0]   owner_q, owner_d;
  logic [NUM_CORES-1:0] grant_q, grant_d;
  logic [NUM_CORES-1:0] ack_q, ack_d;
  logic                 we_q, we_d;
  logic [1:0]           opc_q, opc_d;
  logic [7:0]           arg_q, arg_d;
  logic                 busy_q;

  logic [NUM_CORES-1:0] req_eff;
  logic [NUM_CORES-1:0] lock_eff;
  logic [NUM_CORES-1:0] win_oh;
  logic [OWNER_W-1:0]   win;
  logic                 win_vld;
  logic [1:0]           win_opc;
  logic [7:0]           win_arg;
  logic                 own_req;
  logic                 own_req_raw;
  logic                 own_lock;
  logic [1:0]           own_opc;
  logic [7:0]           own_arg;

`ifdef ACCU_ARB_LOCK_TIMEOUT_EN
  localparam int CNT_W =
    (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_CORES-1:0] ign_q, ign_d;
  logic                 to_q, to_d;
  // a lock that timed out stays ignored until the core drops it
  assign lock_eff = CORE_Lock & ~ign_q;
`else
  logic unused_cfg;
  assign unused_cfg = (LOCK_TIMEOUT > 0);
  assign lock_eff   = CORE_Lock;
`endif

  // a core in its Ack cycle cannot win again with a stale Req
  assign req_eff = CORE_Req & ~ack_q;

  // first requester above ptr, else first requester from 0
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    win_opc = '0;
    win_arg = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!win_vld && req_eff[i] && OWNER_W'(i) > ptr_q) begin
        win_vld = 1'b1;
        win     = OWNER_W'(i);
        win_opc = CORE_OPCode[2*i +: 2];
        win_arg = CORE_ArgToSet[8*i +: 8];
      end
    end
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!win_vld && req_eff[i] && OWNER_W'(i) <= ptr_q) begin
        win_vld = 1'b1;
        win     = OWNER_W'(i);
        win_opc = CORE_OPCode[2*i +: 2];
        win_arg = CORE_ArgToSet[8*i +: 8];
      end
    end
    for (int i = 0; i < NUM_CORES; i++) begin
      win_oh[i] = (OWNER_W'(i) == win);
    end
  end

  always_comb begin
    own_req     = 1'b0;
    own_req_raw = 1'b0;
    own_lock    = 1'b0;
    own_opc     = '0;
    own_arg     = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (OWNER_W'(i) == owner_q) begin
        own_req     = req_eff[i];
        own_req_raw = CORE_Req[i];
        own_lock    = lock_eff[i];
        own_opc     = CORE_OPCode[2*i +: 2];
        own_arg     = CORE_ArgToSet[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    ack_d   = '0;
    we_d    = 1'b0;
    opc_d   = opc_q;
    arg_d   = arg_q;
`ifdef ACCU_ARB_LOCK_TIMEOUT_EN
    cnt_d   = cnt_q;
    ign_d   = ign_q & CORE_Lock;
    to_d    = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d = S_WRITE;
          grant_d = win_oh;
          owner_d = win;
          we_d    = 1'b1;
          opc_d   = win_opc;
          arg_d   = win_arg;
        end
      end
      S_WRITE: begin
        ack_d = grant_q;
        ptr_d = owner_q;
        if (own_lock) begin
          state_d = S_LOCKED;
`ifdef ACCU_ARB_LOCK_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          state_d = S_IDLE;
          grant_d = '0;
          owner_d = '0;
        end
      end
      S_LOCKED: begin
        if (own_req) begin
          state_d = S_WRITE;
          we_d    = 1'b1;
          opc_d   = own_opc;
          arg_d   = own_arg;
`ifdef ACCU_ARB_LOCK_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else if (!own_lock && !own_req_raw) begin
          state_d = S_IDLE;
          grant_d = '0;
          owner_d = '0;
`ifdef ACCU_ARB_LOCK_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT-1)) begin
          state_d = S_IDLE;
          grant_d = '0;
          owner_d = '0;
          to_d    = 1'b1;
          ign_d   = ign_d | grant_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge CPU_Reset_N) begin
    if (!CPU_Reset_N) begin
      state_q <= S_IDLE;
      ptr_q   <= OWNER_W'(NUM_CORES-1);
      owner_q <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      we_q    <= 1'b0;
      opc_q   <= '0;
      arg_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      we_q    <= we_d;
      opc_q   <= opc_d;
      arg_q   <= arg_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

`ifdef ACCU_ARB_LOCK_TIMEOUT_EN
  always_ff @(posedge CLK or negedge CPU_Reset_N) begin
    if (!CPU_Reset_N) begin
      cnt_q <= '0;
      ign_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ign_q <= ign_d;
      to_q  <= to_d;
    end
  end
  assign LOCK_Timeout = to_q;
`else
  assign LOCK_Timeout = 1'b0;
`endif

  assign CORE_Grant    = grant_q;
  assign CORE_Ack      = ack_q;
  assign ACCU_WE       = we_q;
  assign ACCU_OPCode   = opc_q;
  assign ACCU_ArgToSet = arg_q;
  assign ACCU_Owner    = owner_q;
  assign ARB_Busy      = busy_q;

endmodule

// File: tb/tb_accu_arbiter.sv
// tb_accu_arbiter: directed table plus hand sequences for accu_arbiter.
// Lock-timeout sequence depends on ACCU_ARB_LOCK_TIMEOUT_EN.
module tb_accu_arbiter;

  logic        CLK = 1'b0;
  logic        CPU_Reset_N = 1'b0;
  logic [3:0]  CORE_Req = '0;
  logic [3:0]  CORE_Lock = '0;
  logic [7:0]  CORE_OPCode = '0;
  logic [31:0] CORE_ArgToSet = '0;
  logic [3:0]  CORE_Grant;
  logic [3:0]  CORE_Ack;
  logic        ACCU_WE;
  logic [1:0]  ACCU_OPCode;
  logic [7:0]  ACCU_ArgToSet;
  logic [1:0]  ACCU_Owner;
  logic        ARB_Busy;
  logic        LOCK_Timeout;

  int n_cmp = 0;
  int n_bad = 0;

  accu_arbiter #(
    .NUM_CORES(4),
    .OWNER_W(2),
    .LOCK_TIMEOUT(8)
  ) dut (
    .CLK(CLK),
    .CPU_Reset_N(CPU_Reset_N),
    .CORE_Req(CORE_Req),
    .CORE_Lock(CORE_Lock),
    .CORE_OPCode(CORE_OPCode),
    .CORE_ArgToSet(CORE_ArgToSet),
    .CORE_Grant(CORE_Grant),
    .CORE_Ack(CORE_Ack),
    .ACCU_WE(ACCU_WE),
    .ACCU_OPCode(ACCU_OPCode),
    .ACCU_ArgToSet(ACCU_ArgToSet),
    .ACCU_Owner(ACCU_Owner),
    .ARB_Busy(ARB_Busy),
    .LOCK_Timeout(LOCK_Timeout)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [7:0]  opc;
    logic [31:0] arg;
    logic [3:0]  e_grant;
    logic [3:0]  e_ack;
    logic        e_we;
    logic [1:0]  e_opc;
    logic [7:0]  e_arg;
    logic [1:0]  e_own;
    logic        e_busy;
    logic        busy_chk;
  } vec_t;

  vec_t tv [12];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    CORE_Req    = '0;
    CORE_Lock   = '0;
    CPU_Reset_N = 1'b0;
    step();
    chk("rst_grant", 32'(CORE_Grant), 32'h0);
    chk("rst_ack", 32'(CORE_Ack), 32'h0);
    chk("rst_we", 32'(ACCU_WE), 32'h0);
    chk("rst_owner", 32'(ACCU_Owner), 32'h0);
    chk("rst_busy", 32'(ARB_Busy), 32'h0);
    chk("rst_to", 32'(LOCK_Timeout), 32'h0);
    CPU_Reset_N = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // single write, then 4-way round robin from reset
    tv[0]  = '{1, 4'h1, 8'h00, 32'h5A, 4'h1, 4'h0, 1, 2'd0, 8'h5A, 2'd0, 1, 1};
    tv[1]  = '{0, 4'h1, 8'h00, 32'h5A, 4'h0, 4'h1, 0, 2'd0, 8'h00, 2'd0, 0, 0};
    tv[2]  = '{0, 4'h0, 8'h00, 32'h5A, 4'h0, 4'h0, 0, 2'd0, 8'h00, 2'd0, 0, 1};
    tv[3]  = '{1, 4'hF, 8'hE4, 32'h13121110, 4'h1, 4'h0, 1, 2'd0, 8'h10, 2'd0, 1, 1};
    tv[4]  = '{0, 4'hF, 8'hE4, 32'h13121110, 4'h0, 4'h1, 0, 2'd0, 8'h00, 2'd0, 0, 0};
    tv[5]  = '{0, 4'hE, 8'hE4, 32'h13121110, 4'h2, 4'h0, 1, 2'd1, 8'h11, 2'd1, 1, 1};
    tv[6]  = '{0, 4'hE, 8'hE4, 32'h13121110, 4'h0, 4'h2, 0, 2'd0, 8'h00, 2'd0, 0, 0};
    tv[7]  = '{0, 4'hC, 8'hE4, 32'h13121110, 4'h4, 4'h0, 1, 2'd2, 8'h12, 2'd2, 1, 1};
    tv[8]  = '{0, 4'hC, 8'hE4, 32'h13121110, 4'h0, 4'h4, 0, 2'd0, 8'h00, 2'd0, 0, 0};
    tv[9]  = '{0, 4'h8, 8'hE4, 32'h13121110, 4'h8, 4'h0, 1, 2'd3, 8'h13, 2'd3, 1, 1};
    tv[10] = '{0, 4'h8, 8'hE4, 32'h13121110, 4'h0, 4'h8, 0, 2'd0, 8'h00, 2'd0, 0, 0};
    tv[11] = '{0, 4'h0, 8'hE4, 32'h13121110, 4'h0, 4'h0, 0, 2'd0, 8'h00, 2'd0, 0, 1};

    for (int k = 0; k < 12; k++) begin
      if (tv[k].rst) do_reset();
      CORE_Req      = tv[k].req;
      CORE_OPCode   = tv[k].opc;
      CORE_ArgToSet = tv[k].arg;
      step();
      chk($sformatf("v%0d_grant", k), 32'(CORE_Grant), 32'(tv[k].e_grant));
      chk($sformatf("v%0d_ack", k), 32'(CORE_Ack), 32'(tv[k].e_ack));
      chk($sformatf("v%0d_we", k), 32'(ACCU_WE), 32'(tv[k].e_we));
      chk($sformatf("v%0d_own", k), 32'(ACCU_Owner), 32'(tv[k].e_own));
      if (tv[k].busy_chk)
        chk($sformatf("v%0d_busy", k), 32'(ARB_Busy), 32'(tv[k].e_busy));
      if (tv[k].e_we) begin
        chk($sformatf("v%0d_opc", k), 32'(ACCU_OPCode), 32'(tv[k].e_opc));
        chk($sformatf("v%0d_arg", k), 32'(ACCU_ArgToSet), 32'(tv[k].e_arg));
      end
    end

    // core2 locked burst of three writes; core1 waits
    do_reset();
    CORE_OPCode   = 8'b00_01_10_00;
    CORE_ArgToSet = 32'h00_00_AA_00;
    CORE_Req      = 4'b0100;
    CORE_Lock     = 4'b0100;
    for (int w = 0; w < 3; w++) begin
      CORE_ArgToSet[23:16] = 8'(w + 1);
      if (w > 0) begin
        step();
        chk("lk_gap_we", 32'(ACCU_WE), 32'h0);
        chk("lk_gap_grant", 32'(CORE_Grant), 32'h4);
      end
      step();
      chk("lk_we", 32'(ACCU_WE), 32'h1);
      chk("lk_arg", 32'(ACCU_ArgToSet), 32'(w + 1));
      chk("lk_opc", 32'(ACCU_OPCode), 32'h1);
      chk("lk_grant", 32'(CORE_Grant), 32'h4);
      CORE_Req = 4'b0110;
      step();
      chk("lk_ack", 32'(CORE_Ack), 32'h4);
      chk("lk_hold", 32'(CORE_Grant), 32'h4);
      chk("lk_busy", 32'(ARB_Busy), 32'h1);
    end
    CORE_Req  = 4'b0010;
    CORE_Lock = 4'b0000;
    step();
    chk("lk_rel_grant", 32'(CORE_Grant), 32'h0);
    chk("lk_rel_busy", 32'(ARB_Busy), 32'h0);
    step();
    chk("lk_c1_grant", 32'(CORE_Grant), 32'h2);
    chk("lk_c1_arg", 32'(ACCU_ArgToSet), 32'hAA);
    chk("lk_c1_opc", 32'(ACCU_OPCode), 32'h2);

    // Req held through the Ack cycle is masked
    do_reset();
    CORE_ArgToSet = 32'h33;
    CORE_Req      = 4'b0001;
    step();
    chk("hold_we1", 32'(ACCU_WE), 32'h1);
    step();
    chk("hold_ack", 32'(CORE_Ack), 32'h1);
    step();
    chk("hold_mask_we", 32'(ACCU_WE), 32'h0);
    chk("hold_mask_grant", 32'(CORE_Grant), 32'h0);
    CORE_Req = 4'b0000;
    step();
    chk("hold_one_we", 32'(ACCU_WE), 32'h0);
    CORE_Req = 4'b0001;
    step();
    chk("hold2_we", 32'(ACCU_WE), 32'h1);
    step();
    chk("hold2_ack", 32'(CORE_Ack), 32'h1);
    step();
    chk("hold2_mask", 32'(ACCU_WE), 32'h0);
    step();
    chk("hold2_again", 32'(ACCU_WE), 32'h1);

    // reset asserted mid-write
    do_reset();
    CORE_Req = 4'b0100;
    step();
    chk("mid_we_pre", 32'(ACCU_WE), 32'h1);
    #1;
    CPU_Reset_N = 1'b0;
    #1;
    chk("mid_we", 32'(ACCU_WE), 32'h0);
    chk("mid_grant", 32'(CORE_Grant), 32'h0);
    chk("mid_ack", 32'(CORE_Ack), 32'h0);
    @(negedge CLK);
    CPU_Reset_N = 1'b1;
    CORE_Req    = 4'b0101;
    step();
    chk("mid_prio", 32'(CORE_Grant), 32'h1);
    chk("mid_noack", 32'(CORE_Ack), 32'h0);
    step();
    chk("mid_ack0", 32'(CORE_Ack), 32'h1);

    // core3 locks with nothing more to write, core0 pending
    do_reset();
    CORE_Req  = 4'b1000;
    CORE_Lock = 4'b1000;
    step();
    chk("to_we", 32'(ACCU_WE), 32'h1);
    step();
    chk("to_ack", 32'(CORE_Ack), 32'h8);
    CORE_Req = 4'b0001;
`ifdef ACCU_ARB_LOCK_TIMEOUT_EN
    for (int c = 0; c < 7; c++) begin
      step();
      chk("to_wait_pulse", 32'(LOCK_Timeout), 32'h0);
      chk("to_wait_grant", 32'(CORE_Grant), 32'h8);
    end
    step();
    chk("to_pulse", 32'(LOCK_Timeout), 32'h1);
    chk("to_grant_clr", 32'(CORE_Grant), 32'h0);
    step();
    chk("to_pulse_end", 32'(LOCK_Timeout), 32'h0);
    chk("to_next", 32'(CORE_Grant), 32'h1);
    chk("to_next_we", 32'(ACCU_WE), 32'h1);
`else
    for (int c = 0; c < 12; c++) begin
      step();
      chk("nto_pulse", 32'(LOCK_Timeout), 32'h0);
      chk("nto_grant", 32'(CORE_Grant), 32'h8);
    end
    CORE_Lock = 4'b0000;
    step();
    chk("nto_rel", 32'(CORE_Grant), 32'h0);
    step();
    chk("nto_next", 32'(CORE_Grant), 32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
